// File: rtl/activation_serializer_pkg.sv
// rtl/activation_serializer_pkg.sv - shared state enum and lane-index width for the activation path
package activation_serializer_pkg;

    localparam int LANE_IDX_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/activation_serializer_if.sv
// rtl/activation_serializer_if.sv - lane beat stream from the serializer to its consumer
interface activation_serializer_if #(
    parameter int N = 16
);
    import activation_serializer_pkg::*;

    logic                  valid_o;
    logic                  ready_i;
    logic [N-1:0]          data_o;
    logic [LANE_IDX_W-1:0] index_o;
    logic                  last_o;

    modport master (
        output valid_o,
        output data_o,
        output index_o,
        output last_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  data_o,
        input  index_o,
        input  last_o,
        output ready_i
    );

endinterface

// File: rtl/activation_serializer_running_argmax.sv
// rtl/activation_serializer_running_argmax.sv - signed compare-and-hold of the largest lane seen
module running_argmax
    import activation_serializer_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  first_i,
    input  logic                  update_i,
    input  logic [N-1:0]          value_i,
    input  logic [LANE_IDX_W-1:0] index_i,
    output logic [N-1:0]          max_value_o,
    output logic [LANE_IDX_W-1:0] max_index_o
);

    logic [N-1:0]          max_value_q, max_value_d;
    logic [LANE_IDX_W-1:0] max_index_q, max_index_d;

    // Strict greater-than so that ties keep the earliest lane.
    always_comb begin
        max_value_d = max_value_q;
        max_index_d = max_index_q;
        if (clear_i) begin
            max_value_d = '0;
            max_index_d = '0;
        end else if (update_i && (first_i || ($signed(value_i) > $signed(max_value_q)))) begin
            max_value_d = value_i;
            max_index_d = index_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_value_q <= '0;
            max_index_q <= '0;
        end else begin
            max_value_q <= max_value_d;
            max_index_q <= max_index_d;
        end
    end

    assign max_value_o = max_value_q;
    assign max_index_o = max_index_q;

endmodule

// File: rtl/activation_serializer.sv
// rtl/activation_serializer.sv - captures activated lanes and streams them one per beat with running argmax
module activation_serializer
    import activation_serializer_pkg::*;
#(
    parameter int N           = 16,
    parameter int EngineCount = 4095
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         load_i,
    input  logic [LANE_IDX_W-1:0]        count_i,
    input  logic [N*EngineCount-1:0]     value_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [N-1:0]                 max_value_o,
    output logic [LANE_IDX_W-1:0]        max_index_o,
    activation_serializer_if.master      m_if
);

    localparam logic [LANE_IDX_W-1:0] ENGINE_CNT = LANE_IDX_W'(EngineCount);

    ser_state_e            state_q, state_d;
    logic [LANE_IDX_W-1:0] count_q, count_d;
    logic [LANE_IDX_W-1:0] index_q, index_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic [N-1:0]          capture_q [EngineCount];
    logic [N-1:0]          data_mux;
    logic [LANE_IDX_W-1:0] eff_count;
    logic [LANE_IDX_W-1:0] next_index;
    logic                  capture_en, am_clear, am_update, xfer;

    assign eff_count  = (count_i > ENGINE_CNT) ? ENGINE_CNT : count_i;
    assign next_index = index_q + LANE_IDX_W'(1);
    assign xfer       = valid_q && m_if.ready_i;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = 1'b0;
        capture_en = 1'b0;
        am_clear   = 1'b0;
        am_update  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    capture_en = 1'b1;
                    am_clear   = 1'b1;
                    count_d    = eff_count;
                    index_d    = '0;
                    busy_d     = 1'b1;
                    if (eff_count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_STREAM;
                        valid_d = 1'b1;
                        last_d  = (eff_count == LANE_IDX_W'(1));
                    end
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    am_update = 1'b1;
                    index_d   = next_index;
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        last_d = (next_index == count_q - LANE_IDX_W'(1));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            index_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Capture storage carries no reset; its contents only matter while valid is high.
    always_ff @(posedge clk_i) begin
        if (capture_en) begin
            for (int i = 0; i < EngineCount; i++) begin
                capture_q[i] <= value_i[i*N +: N];
            end
        end
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < EngineCount; i++) begin
            if (valid_q && (index_q == LANE_IDX_W'(i))) begin
                data_mux = capture_q[i];
            end
        end
    end

    running_argmax #(.N(N)) u_argmax (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (am_clear),
        .first_i     (index_q == '0),
        .update_i    (am_update),
        .value_i     (data_mux),
        .index_i     (index_q),
        .max_value_o (max_value_o),
        .max_index_o (max_index_o)
    );

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign m_if.valid_o = valid_q;
    assign m_if.data_o  = data_mux;
    assign m_if.index_o = index_q;
    assign m_if.last_o  = last_q;

endmodule

// File: tb/tb_activation_serializer.sv
// tb/tb_activation_serializer.sv - directed self-checking bench for activation_serializer
module tb_activation_serializer;

    localparam int N  = 16;
    localparam int EC = 10;

    logic            clk_i;
    logic            rst_ni;
    logic            load_i;
    logic [11:0]     count_i;
    logic [N*EC-1:0] value_i;
    logic            busy_o;
    logic            done_o;
    logic [N-1:0]    max_value_o;
    logic [11:0]     max_index_o;

    activation_serializer_if #(.N(N)) s_if ();

    activation_serializer #(.N(N), .EngineCount(EC)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load_i),
        .count_i     (count_i),
        .value_i     (value_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .max_value_o (max_value_o),
        .max_index_o (max_index_o),
        .m_if        (s_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks;
    int errors;

    int lanes [EC];
    int alt   [EC];

    int b_data [64];
    int b_idx  [64];
    int b_last [64];
    int b_cyc  [64];
    int nbeats, nvalid, done_cyc, done_cnt, stall_err, busy_after, mv, mi;

    task automatic apply_lanes(input bit use_alt);
        for (int i = 0; i < EC; i++) begin
            value_i[i*N +: N] = use_alt ? 16'(alt[i]) : 16'(lanes[i]);
        end
    endtask

    // Entered at posedge+1 of an IDLE cycle; the load is accepted on the next edge.
    task automatic do_load(input int cnt);
        apply_lanes(1'b0);
        count_i = 12'(cnt);
        load_i  = 1'b1;
        @(posedge clk_i);
        #1;
        load_i  = 1'b0;
    endtask

    // Records beats, stall stability and the done pulse; cycle 1 is the first cycle after the load edge.
    task automatic collect(input bit toggle, input int load_at, input int budget);
        logic         held;
        logic [N-1:0] hd;
        logic [11:0]  hi;
        logic         hl;
        nbeats = 0; nvalid = 0; done_cyc = -1; done_cnt = 0; stall_err = 0;
        busy_after = -1; mv = 0; mi = 0; held = 1'b0; hd = '0; hi = '0; hl = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            s_if.ready_i = toggle ? (c % 2 == 1) : 1'b1;
            if (c == load_at) begin
                apply_lanes(1'b1);
                count_i = 12'd2;
                load_i  = 1'b1;
            end else begin
                load_i = 1'b0;
            end
            #1;
            if (held && (!s_if.valid_o || s_if.data_o !== hd || s_if.index_o !== hi || s_if.last_o !== hl))
                stall_err++;
            held = 1'b0;
            if (s_if.valid_o) nvalid++;
            if (s_if.valid_o && s_if.ready_i) begin
                if (nbeats < 64) begin
                    b_data[nbeats] = int'($signed(s_if.data_o));
                    b_idx[nbeats]  = int'(s_if.index_o);
                    b_last[nbeats] = int'(s_if.last_o);
                    b_cyc[nbeats]  = c;
                end
                nbeats++;
            end else if (s_if.valid_o) begin
                held = 1'b1; hd = s_if.data_o; hi = s_if.index_o; hl = s_if.last_o;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    mv = int'($signed(max_value_o));
                    mi = int'(max_index_o);
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = int'(busy_o);
                break;
            end
            @(posedge clk_i);
            #1;
        end
        load_i = 1'b0;
        s_if.ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; load_i = 1'b0; count_i = '0; value_i = '0; s_if.ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({busy_o, s_if.valid_o, s_if.last_o, done_o} !== 4'b0 || s_if.data_o !== '0 ||
            s_if.index_o !== '0 || max_value_o !== '0 || max_index_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b last=%b done=%b data=%h idx=%0d max=%h maxi=%0d, all must be 0",
                     busy_o, s_if.valid_o, s_if.last_o, done_o, s_if.data_o, s_if.index_o, max_value_o, max_index_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_full_stream();
        int exp [EC] = '{3, -1, 7, 7, 0, 2, 9, -5, 9, 1};
        lanes = exp;
        do_load(10);
        checks++;
        if (busy_o !== 1'b1 || s_if.valid_o !== 1'b1) begin
            errors++; $display("FAIL full_start: busy=%b valid=%b, required 1 1", busy_o, s_if.valid_o);
        end
        collect(1'b0, 0, 40);
        checks++;
        if (nbeats !== 10) begin errors++; $display("FAIL full_beats: got %0d, required 10", nbeats); end
        for (int i = 0; i < 10 && i < nbeats; i++) begin
            checks++;
            if (b_data[i] !== exp[i] || b_idx[i] !== i || b_last[i] !== int'(i == 9) || b_cyc[i] !== i + 1) begin
                errors++;
                $display("FAIL full_beat%0d: data=%0d idx=%0d last=%0d cyc=%0d, required %0d %0d %0d %0d",
                         i, b_data[i], b_idx[i], b_last[i], b_cyc[i], exp[i], i, int'(i == 9), i + 1);
            end
        end
        checks++;
        if (done_cyc !== 11 || done_cnt !== 1) begin
            errors++; $display("FAIL full_done: cycle=%0d count=%0d, required 11 1", done_cyc, done_cnt);
        end
        checks++;
        if (mv !== 9 || mi !== 6) begin errors++; $display("FAIL full_argmax: %0d@%0d, required 9@6", mv, mi); end
        checks++;
        if (busy_after !== 0) begin errors++; $display("FAIL full_busy_after: %0d, required 0", busy_after); end
    endtask

    task automatic test_backpressure();
        int exp [EC] = '{3, -1, 7, 7, 0, 2, 9, -5, 9, 1};
        lanes = exp;
        do_load(10);
        collect(1'b1, 0, 60);
        checks++;
        if (nbeats !== 10 || stall_err !== 0) begin
            errors++; $display("FAIL bp_beats: beats=%0d stall_err=%0d, required 10 0", nbeats, stall_err);
        end
        for (int i = 0; i < 10 && i < nbeats; i++) begin
            checks++;
            if (b_data[i] !== exp[i] || b_idx[i] !== i || b_cyc[i] !== 2 * i + 1) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%0d idx=%0d cyc=%0d, required %0d %0d %0d",
                         i, b_data[i], b_idx[i], b_cyc[i], exp[i], i, 2 * i + 1);
            end
        end
        checks++;
        if (nvalid !== 19 || done_cyc !== 20) begin
            errors++; $display("FAIL bp_timing: valid_cycles=%0d done=%0d, required 19 20", nvalid, done_cyc);
        end
        checks++;
        if (mv !== 9 || mi !== 6) begin errors++; $display("FAIL bp_argmax: %0d@%0d, required 9@6", mv, mi); end
    endtask

    task automatic test_negative();
        lanes = '{-8, -3, -3, -9, 50, 60, 70, 80, 90, 100};
        do_load(4);
        collect(1'b0, 0, 30);
        checks++;
        if (nbeats !== 4 || done_cyc !== 5) begin
            errors++; $display("FAIL neg_beats: beats=%0d done=%0d, required 4 5", nbeats, done_cyc);
        end
        checks++;
        if (mv !== -3 || mi !== 1) begin errors++; $display("FAIL neg_argmax: %0d@%0d, required -3@1", mv, mi); end
    endtask

    task automatic test_zero_count();
        lanes = '{40, 41, 42, 43, 44, 45, 46, 47, 48, 49};
        do_load(0);
        collect(1'b0, 0, 20);
        checks++;
        if (nvalid !== 0 || done_cyc !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL zero_count: valid_cycles=%0d done=%0d pulses=%0d, required 0 1 1", nvalid, done_cyc, done_cnt);
        end
        checks++;
        if (mv !== 0 || mi !== 0) begin errors++; $display("FAIL zero_argmax: %0d@%0d, required 0@0", mv, mi); end
    endtask

    task automatic test_count_clamp();
        lanes = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -10};
        do_load(4000);
        collect(1'b0, 0, 40);
        checks++;
        if (nbeats !== 10 || done_cyc !== 11) begin
            errors++; $display("FAIL clamp_beats: beats=%0d done=%0d, required 10 11", nbeats, done_cyc);
        end
        checks++;
        if (nbeats >= 10 && (b_idx[9] !== 9 || b_last[9] !== 1 || b_data[9] !== -10)) begin
            errors++; $display("FAIL clamp_last: idx=%0d last=%0d data=%0d, required 9 1 -10", b_idx[9], b_last[9], b_data[9]);
        end
        checks++;
        if (mv !== 9 || mi !== 8) begin errors++; $display("FAIL clamp_argmax: %0d@%0d, required 9@8", mv, mi); end
    endtask

    task automatic test_load_ignored();
        int exp [EC] = '{10, 20, 30, 40, 50, 60, 5, 4, 3, 2};
        lanes = exp;
        alt   = '{99, 99, 99, 99, 99, 99, 99, 99, 99, 99};
        do_load(6);
        collect(1'b0, 3, 40);
        checks++;
        if (nbeats !== 6 || done_cyc !== 7) begin
            errors++; $display("FAIL ign_beats: beats=%0d done=%0d, required 6 7", nbeats, done_cyc);
        end
        for (int i = 0; i < 6 && i < nbeats; i++) begin
            checks++;
            if (b_data[i] !== exp[i] || b_idx[i] !== i) begin
                errors++; $display("FAIL ign_beat%0d: data=%0d idx=%0d, required %0d %0d", i, b_data[i], b_idx[i], exp[i], i);
            end
        end
        checks++;
        if (mv !== 60 || mi !== 5) begin errors++; $display("FAIL ign_argmax: %0d@%0d, required 60@5", mv, mi); end
    endtask

    task automatic test_reset_abort();
        int  stray;
        bit  reached;
        int  exp [EC] = '{5, 6, 4, 0, 0, 0, 0, 0, 0, 0};
        lanes = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        do_load(10);
        s_if.ready_i = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (s_if.valid_o && s_if.index_o == 12'd4) begin reached = 1'b1; break; end
            @(posedge clk_i);
            #1;
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL abort_reach: beat 4 not presented, required within 20 cycles"); end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, s_if.valid_o, s_if.last_o, done_o} !== 4'b0 || s_if.data_o !== '0 ||
            s_if.index_o !== '0 || max_value_o !== '0 || max_index_o !== '0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b valid=%b last=%b done=%b data=%h idx=%0d max=%h, all must be 0",
                     busy_o, s_if.valid_o, s_if.last_o, done_o, s_if.data_o, s_if.index_o, max_value_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o || s_if.valid_o || busy_o) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL abort_no_done: %0d active cycles, required 0", stray); end
        lanes = exp;
        do_load(3);
        collect(1'b0, 0, 20);
        checks++;
        if (nbeats !== 3 || done_cyc !== 4) begin
            errors++; $display("FAIL abort_restart: beats=%0d done=%0d, required 3 4", nbeats, done_cyc);
        end
        checks++;
        if (nbeats >= 3 && (b_idx[0] !== 0 || b_data[0] !== 5 || b_data[2] !== 4 || b_last[2] !== 1)) begin
            errors++;
            $display("FAIL abort_beats: idx0=%0d d0=%0d d2=%0d last2=%0d, required 0 5 4 1", b_idx[0], b_data[0], b_data[2], b_last[2]);
        end
        checks++;
        if (mv !== 6 || mi !== 1) begin errors++; $display("FAIL abort_argmax: %0d@%0d, required 6@1", mv, mi); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_stream();
        test_backpressure();
        test_negative();
        test_zero_count();
        test_count_clamp();
        test_load_ignored();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
